// File: rtl/bitwise_accum_pkg.sv
// Shared constants for the bitwise fold block and its consumers (e.g. the ALU).
// Holds the fold-mode codes and the frame-controller state codes.
package bitwise_accum_pkg;

  // Fold operation applied across the words of a frame.
  // NOR accumulates as OR; the inversion is applied once at the output.
  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_NOR = 2'b11
  } mode_e;

  // Frame controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/bitwise_accum_op.sv
// Combinational WIDTH-bit bitwise gate: y = a OR/AND/XOR b, selected by mode.
// NOR is treated as OR here; the fold's final inversion is done by the caller.
// Ports:
//   a, b  : operands (WIDTH bits)
//   mode  : fold mode code (mode_e)
//   y     : result (WIDTH bits)
module bitwise_op
  import bitwise_accum_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  mode_e            mode,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a | b;
    case (mode)
      MODE_AND: y = a & b;
      MODE_XOR: y = a ^ b;
      default:  y = a | b;
    endcase
  end

endmodule

// File: rtl/bitwise_accum.sv
// Sequential bitwise fold: combines a frame of up to FRAME_LEN WIDTH-bit words
// into one word using OR, AND, XOR or NOR, with valid/ready on both sides.
// Ports:
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   mode                  : fold op, sampled on the first beat of a frame only
//   in_valid/in_ready     : input handshake; in_ready depends on state only
//   in_data, in_last      : word to fold, early end-of-frame marker
//   out_valid/out_ready   : result handshake
//   out_data              : folded word (inverted for NOR)
//   out_any               : reduction OR of out_data
//   out_count             : number of words folded (1..FRAME_LEN)
module bitwise_accum
  import bitwise_accum_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int FRAME_LEN = 8,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_any,
  output logic [CNT_W-1:0] out_count
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] op_y;
  logic [CNT_W-1:0] count_inc;
  logic             accept;

  bitwise_op #(
    .WIDTH (WIDTH)
  ) u_op (
    .a    (acc_q),
    .b    (in_data),
    .mode (mode_q),
    .y    (op_y)
  );

  // Ready is a pure state decode so there is no path from out_ready.
  assign in_ready  = (state_q != ST_DONE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = in_data;
          mode_d  = mode_e'(mode);
          count_d = CNT_W'(1);
          state_d = (in_last || FRAME_LEN == 1) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d   = op_y;
          count_d = count_inc;
          // A full frame forces completion, so the counter never passes FRAME_LEN.
          state_d = (in_last || count_inc == CNT_W'(FRAME_LEN)) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_OR;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  // Outputs track acc/count in every state; they are only meaningful in DONE.
  assign out_data  = (mode_q == MODE_NOR) ? ~acc_q : acc_q;
  assign out_any   = |out_data;
  assign out_count = count_q;

endmodule

// File: tb/tb_bitwise_accum.sv
module tb_bitwise_accum;

  localparam int WIDTH     = 16;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_any;
  logic [CNT_W-1:0] out_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] words [FRAME_LEN];

  bitwise_accum #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_any   (out_any),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference fold straight from the mode definitions.
  function automatic logic [WIDTH-1:0] model_fold(input logic [1:0] m, input int len);
    logic [WIDTH-1:0] r;
    r = words[0];
    for (int i = 1; i < len; i++) begin
      case (m)
        2'b00:   r = r | words[i];
        2'b01:   r = r & words[i];
        2'b10:   r = r ^ words[i];
        default: r = r | words[i];
      endcase
    end
    if (m == 2'b11) r = ~r;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one frame, wait out `hold` back-pressured cycles, then release it.
  task automatic send_frame(input logic [1:0] m, input logic [1:0] m_later, input int len,
                            input logic use_last, input int hold, input logic toggle,
                            input logic gaps);
    logic [WIDTH-1:0] exp;
    exp = model_fold(m, len);
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = WIDTH'($urandom);
          mode     = 2'($urandom);
          tick();
          check("idle_gap_out_valid", 32'(out_valid), 32'd0);
        end
      end
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = use_last && (i == len - 1);
      mode     = (i == 0) ? m : m_later;
      check("beat_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i < len - 1) check("mid_frame_out_valid", 32'(out_valid), 32'd0);
    end
    check("done_out_valid", 32'(out_valid), 32'd1);
    check("done_out_data", 32'(out_data), 32'(exp));
    check("done_out_any", 32'(out_any), 32'(|exp));
    check("done_out_count", 32'(out_count), 32'(len));
    check("done_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (toggle) begin
        in_valid = 1'($urandom);
        in_data  = WIDTH'($urandom);
        in_last  = 1'($urandom);
      end
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_data", 32'(out_data), 32'(exp));
      check("hold_out_count", 32'(out_count), 32'(len));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    // Release with a beat presented: it must not be taken in DONE.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hDEAD;
    in_last   = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    mode      = 2'b00;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // OR, full frame without in_last
    words[0] = 16'h0001; words[1] = 16'h0010; words[2] = 16'h0100; words[3] = 16'h1000;
    send_frame(2'b00, 2'b00, 4, 1'b0, 0, 1'b0, 1'b0);
    check("or_literal", 32'(model_fold(2'b00, 4)), 32'h1111);

    // AND with mode flipped to XOR after the first beat
    words[0] = 16'hFFFF; words[1] = 16'h0F0F; words[2] = 16'h00FF; words[3] = 16'hF0FF;
    send_frame(2'b01, 2'b10, 4, 1'b0, 0, 1'b0, 1'b0);

    // XOR, early termination on beat 2
    words[0] = 16'hAAAA; words[1] = 16'hFFFF;
    send_frame(2'b10, 2'b10, 2, 1'b1, 0, 1'b0, 1'b0);

    // NOR of zeros, then OR of a single zero
    for (int i = 0; i < FRAME_LEN; i++) words[i] = 16'h0000;
    send_frame(2'b11, 2'b11, 4, 1'b0, 0, 1'b0, 1'b0);
    send_frame(2'b00, 2'b00, 1, 1'b1, 0, 1'b0, 1'b0);

    // Back-pressure with input noise in DONE
    words[0] = 16'h1234; words[1] = 16'h8001; words[2] = 16'h0420;
    send_frame(2'b00, 2'b01, 3, 1'b1, 5, 1'b1, 1'b0);

    // Reset in the middle of a frame discards it
    mode = 2'b00; in_valid = 1'b1; in_data = 16'h00F0; tick();
    in_data = 16'h0F00; tick();
    in_valid = 1'b0;
    reset = 1'b1; tick();
    reset = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_count", 32'(out_count), 32'd0);
    words[0] = 16'h0001;
    send_frame(2'b00, 2'b00, 1, 1'b1, 0, 1'b0, 1'b0);

    // Randomised frames
    for (int f = 0; f < 200; f++) begin
      int len;
      logic ul;
      len = $urandom_range(1, FRAME_LEN);
      ul  = (len < FRAME_LEN) ? 1'b1 : 1'($urandom);
      for (int i = 0; i < FRAME_LEN; i++) begin
        case ($urandom_range(0, 3))
          0:       words[i] = 16'hFFFF ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
          1:       words[i] = WIDTH'(1 << $urandom_range(0, WIDTH - 1));
          default: words[i] = WIDTH'($urandom);
        endcase
      end
      send_frame(2'($urandom), 2'($urandom), len, ul, $urandom_range(0, 3),
                 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
